rol_seq: RTL and testbench
==========================

# rol_seq

Sequential rotate-left unit for the datapath ALU. It is the left-direction counterpart of the existing combinational rotate-right. It accepts an operand `Rb` and a rotate amount `Rc` on a `start` pulse. It then rotates through a logarithmic shifter, one stage per clock, and returns `Ra` with a one-cycle `done` pulse. Use it where a multi-cycle ROL fits the control-unit timing better than a full-width single-cycle barrel.

## Interface
- `WIDTH`, default 32, operand width; must be a power of two, ≥2.
- `SHW`, default 5, rotate-amount width, equal to log2(WIDTH); derived, not overridden.

Ports:
- `clk`: input, 1 bit, rising-edge clock.
- `clr`: input, 1 bit, synchronous reset, active-high.
- `start`: input, 1 bit, request. Sampled only when idle.
- `Rb`: input, WIDTH bits, operand. Sampled with `start`.
- `Rc`: input, SHW bits, rotate-left amount. Sampled with `start`.
- `Ra`: output, WIDTH bits, registered result. Held until the next completion or `clr`.
- `busy`: output, 1 bit, high while an operation is in flight.
- `done`: output, 1 bit, one-cycle pulse; `Ra` is valid from this cycle.

## Operation
- State machine: IDLE, SHIFT.
- IDLE:
  - If `start`=1 at a rising edge, load the work register from `Rb` and the amount register from `Rc`.
  - Clear the stage counter to 0, set `busy`=1, and go to SHIFT.
  - If `start`=0, stay in IDLE.
- SHIFT, stage k = 0..SHW-1, one stage per edge:
  - If amt[k]=1, work ← {work[WIDTH-1-2^k:0], work[WIDTH-1:WIDTH-2^k]}, i.e. rotate left by 2^k.
  - If amt[k]=0, work is unchanged.
  - Then increment k.
- Final stage (k=SHW-1), on that edge:
  - `Ra` ← the stage-k result.
  - `done` ← 1, `busy` ← 0, state ← IDLE.
- Result: Ra = (Rb << Rc) | (Rb >> (WIDTH-Rc)), taken modulo WIDTH.
  - Rc=0 gives Ra=Rb.
  - No carry or flags are produced.
- `start` while `busy`=1 is ignored.
- `Rb`/`Rc` changes while busy have no effect, because the operands were captured at the start edge.
- `done` stays high for exactly one cycle and never coincides with `busy`=1.
- `clr`=1 at any edge, including mid-SHIFT, has priority over everything:
  - state ← IDLE, and work, amt and k ← 0.
  - `Ra` ← 0, `busy` ← 0, `done` ← 0.
  - The in-flight operation is discarded and no `done` is issued for it.
- `clr` and `start` together at the same edge: `clr` wins and the request is dropped.

## Timing
- Reset values: `Ra`=0, `busy`=0, `done`=0.
- Let E0 be the edge at which `start`=1 is sampled in IDLE.
- `busy` is high from after E0 through the cycle ending at E(SHW).
- Stages execute at edges E1..E(SHW).
- `done`=1 and the new `Ra` appear after E(SHW). For WIDTH=32 that is E5, a fixed latency of 5 cycles independent of `Rc`.
- Earliest next accepted `start` is at E(SHW+1), i.e. while `done` is high. Issue interval is SHW+1 = 6 cycles.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
- Reset: hold `clr`=1 for 2 cycles with `start`=1 → `Ra`=0x00000000, `busy`=0, `done`=0; the request is not accepted.
- Basic rotates, checking each result at E5 with a single `done` pulse:
  - Rb=0x80000001, Rc=1 → Ra=0x00000003.
  - Rb=0x12345678, Rc=8 → Ra=0x34567812.
  - Rb=0x00000001, Rc=31 → Ra=0x80000000.
  - Rb=0xDEADBEEF, Rc=0 → Ra=0xDEADBEEF.
- Busy lockout:
  - Start Rb=0x0000000F, Rc=4, then hold `start`=1 with Rb=0xFFFFFFFF for E1..E4 → Ra=0x000000F0 at E5.
  - With `start` still high at E6, a second op is accepted, producing `done` at E11.
- Back-to-back: issue requests every 6 cycles for 10 ops → 10 `done` pulses, each `Ra` matches its own operands, and none are lost.
- Mid-op reset: start Rb=0xAAAA5555, Rc=3, assert `clr` at E3 → from E3 `Ra`=0 and `busy`=0, and no `done` follows. A fresh op after release completes normally.
- Random equivalence: 1000 random (Rb, Rc) → Ra equals the ror result of Rb by (32-Rc) mod 32, and equals the reference model (Rb<<Rc)|(Rb>>(32-Rc)).

Source files
------------

// File: rtl/rol_seq.sv
// Sequential rotate-left: one logarithmic-shifter stage per clock, result
// registered in Ra with a single-cycle done pulse after log2(WIDTH) stages.
module rol_seq #(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] Rb,
    input  logic [SHW-1:0]   Rc,
    output logic [WIDTH-1:0] Ra,
    output logic             busy,
    output logic             done
);

    localparam int unsigned KW = SHW;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] work_q,  work_d;
    logic [SHW-1:0]   amt_q,   amt_d;
    logic [KW-1:0]    k_q,     k_d;
    logic [WIDTH-1:0] ra_q,    ra_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    int unsigned      sh;
    logic [WIDTH-1:0] stage_res;

    // amt is shifted right each stage so bit 0 always selects the current stage
    always_comb begin
        sh        = 32'(1) << k_q;
        stage_res = work_q;
        if (amt_q[0]) begin
            stage_res = (work_q << sh) | (work_q >> (WIDTH - sh));
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        amt_d   = amt_q;
        k_d     = k_q;
        ra_d    = ra_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d  = Rb;
                    amt_d   = Rc;
                    k_d     = '0;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                work_d = stage_res;
                amt_d  = amt_q >> 1;
                k_d    = k_q + KW'(1);
                if (k_q == KW'(SHW - 1)) begin
                    ra_d    = stage_res;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    k_d     = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // clr discards any in-flight operation and suppresses its done
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            amt_q   <= '0;
            k_q     <= '0;
            ra_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            amt_q   <= amt_d;
            k_q     <= k_d;
            ra_q    <= ra_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Ra   = ra_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_rol_seq.sv
// Directed bench for rol_seq (WIDTH=32): fixed 5-cycle latency, busy lockout,
// back-to-back issue, mid-operation clear and random equivalence.
module tb_rol_seq;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [31:0] Rb;
    logic [4:0]  Rc;
    logic [31:0] Ra;
    logic        busy;
    logic        done;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_ra = 32'h0;

    rol_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .Rb    (Rb),
        .Rc    (Rc),
        .Ra    (Ra),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rol_ref(input logic [31:0] b, input int c);
        return (b << c) | (b >> (32 - c));
    endfunction

    function automatic logic [31:0] ror_ref(input logic [31:0] b, input int s);
        return (b >> s) | (b << (32 - s));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op at the next edge (E0) and check every cycle through E5.
    // keep_start leaves start high with junk operands during the op.
    task automatic do_op(input logic [31:0] b, input logic [4:0] c,
                         input logic [31:0] exp, input logic keep_start,
                         input string tag);
        start = 1'b1;
        Rb    = b;
        Rc    = c;
        step();
        if (keep_start) begin
            Rb = 32'hFFFF_FFFF;
            Rc = ~c;
        end else begin
            start = 1'b0;
            Rb    = $urandom;
            Rc    = 5'($urandom);
        end
        chk({tag, "_busy_e0"}, {30'd0, busy, done}, 32'd2);
        for (int i = 1; i < 5; i++) begin
            step();
            chk({tag, "_busy_mid"}, {30'd0, busy, done}, 32'd2);
            chk({tag, "_ra_hold_mid"}, Ra, exp_ra);
        end
        step();
        chk({tag, "_done_e5"}, {30'd0, busy, done}, 32'd1);
        chk({tag, "_ra"}, Ra, exp);
        exp_ra = exp;
    endtask

    initial begin
        logic [31:0] b;
        logic [4:0]  c;

        // Reset with start held high: request must be dropped
        clr   = 1'b1;
        start = 1'b1;
        Rb    = 32'h1234_5678;
        Rc    = 5'd3;
        step();
        step();
        chk("rst_ra", Ra, 32'h0);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        clr   = 1'b0;
        start = 1'b0;
        step();
        chk("rst_no_accept", {30'd0, busy, done}, 32'd0);

        // Basic rotates with hand-computed results
        do_op(32'h8000_0001, 5'd1,  32'h0000_0003, 1'b0, "rot1");
        step();
        chk("rot1_done_pulse", {31'd0, done}, 32'd0);
        chk("rot1_ra_held", Ra, 32'h0000_0003);
        do_op(32'h1234_5678, 5'd8,  32'h3456_7812, 1'b0, "rot8");
        step();
        do_op(32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, "rot31");
        step();
        do_op(32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0, "rot0");
        step();

        // Busy lockout: start held high with junk Rb through E1..E5
        do_op(32'h0000_000F, 5'd4, 32'h0000_00F0, 1'b1, "lock");
        // start still high at E6 with Rb=FFFFFFFF: accepted, done at E11
        do_op(32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFF, 1'b0, "lock2");
        step();
        chk("lock2_done_pulse", {31'd0, done}, 32'd0);

        // Back-to-back every 6 cycles, each next start while done is high
        for (int i = 0; i < 10; i++) begin
            b = 32'h0123_4567 * 32'(i + 3) ^ 32'hA5A5_0000;
            c = 5'(i * 3 + 1);
            do_op(b, c, rol_ref(b, int'(c)), 1'b0, "b2b");
        end
        step();
        chk("b2b_tail_idle", {30'd0, busy, done}, 32'd0);

        // Mid-op clear at E3 discards the op
        start = 1'b1;
        Rb    = 32'hAAAA_5555;
        Rc    = 5'd3;
        step();
        start = 1'b0;
        step();
        step();
        clr = 1'b1;
        step();
        chk("clr_ra", Ra, 32'h0);
        chk("clr_busy_done", {30'd0, busy, done}, 32'd0);
        clr    = 1'b0;
        exp_ra = 32'h0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("clr_no_done", {30'd0, busy, done}, 32'd0);
        end
        do_op(32'hAAAA_5555, 5'd3, 32'h5552_AAAD, 1'b0, "post_clr");
        step();

        // Random equivalence against both rol and ror formulations
        for (int i = 0; i < 1000; i++) begin
            b = $urandom;
            c = 5'($urandom);
            do_op(b, c, rol_ref(b, int'(c)), 1'b0, "rand");
            chk("rand_ror", Ra, ror_ref(b, int'((32 - int'(c)) % 32)));
        end
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
